// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter/rotator that moves the operand one bit per
// clock and publishes only the final value on result with a one-cycle done.
module seq_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data,
  input  logic [4:0]  num,
  input  logic [1:0]  shift_type,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t         state, state_n;
  logic [DW-1:0]  work, work_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [1:0]     op, op_n;
  logic [DW-1:0]  result_n;
  logic           busy_n, done_n;
  logic [DW-1:0]  step_val;

  // One-bit step of the working register for the latched operation.
  always_comb begin
    step_val = work;
    case (op)
      OP_LSL:  step_val = {work[DW-2:0], 1'b0};
      OP_LSR:  step_val = {1'b0, work[DW-1:1]};
      OP_ROL:  step_val = {work[DW-2:0], work[DW-1]};
      OP_ROR:  step_val = {work[0], work[DW-1:1]};
      default: step_val = work;
    endcase
  end

  // Next-state, datapath and output decode; busy/done follow the next state
  // so they come straight out of flops.
  always_comb begin
    state_n  = state;
    work_n   = work;
    cnt_n    = cnt;
    op_n     = op;
    result_n = result;
    case (state)
      IDLE: begin
        if (start) begin
          work_n = data;
          cnt_n  = num;
          op_n   = shift_type;
          if (num == CW'(0)) begin
            result_n = data;
            state_n  = DONE;
          end else begin
            state_n  = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_n = step_val;
        cnt_n  = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          result_n = step_val;
          state_n  = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      op     <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      work   <= work_n;
      cnt    <= cnt_n;
      op     <= op_n;
      result <= result_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: scoreboard of expected results and done cycles.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] data;
  logic [4:0]  num;
  logic [1:0]  shift_type;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_result = '0;

  seq_shifter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data       (data),
    .num        (num),
    .shift_type (shift_type),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #5 clk = ~clk;

  // Cycle index, advanced on each active edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // One-shot reference shift/rotate.
  function automatic logic [31:0] model(input logic [1:0] t, input logic [31:0] d, input logic [4:0] n);
    logic [31:0] r;
    case (t)
      2'b00:   r = d << n;
      2'b01:   r = d >> n;
      2'b10:   r = (n == 0) ? d : ((d << n) | (d >> (32 - int'(n))));
      default: r = (n == 0) ? d : ((d >> n) | (d << (32 - int'(n))));
    endcase
    return r;
  endfunction

  // Scoreboard: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        exp_result = e.res;
      end
    end
  end

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    while (!done && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (!done) check("timeout", 32'(0), 32'(1));
  endtask

  // Run one operation; optionally poke start with junk in the third SHIFT cycle.
  task automatic run_op(input logic [1:0] t, input logic [31:0] d, input logic [4:0] n, input bit poke);
    int k;
    @(negedge clk);
    check("idle_before", 32'(busy), 32'(0));
    start = 1'b1; data = d; num = n; shift_type = t;
    sb_q.push_back('{res: model(t, d, n), cyc: cyc + 1 + n});
    @(negedge clk);
    start = 1'b0; data = $urandom; num = 5'($urandom); shift_type = 2'($urandom);
    k = 0;
    while (!done && k < 40) begin
      check("busy_shift", 32'(busy), 32'(1));
      check("result_hold", result, exp_result);
      if (poke && k == 2) begin
        start = 1'b1; data = 32'hFFFF_FFFF; num = 5'd3; shift_type = 2'b00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (!done) check("timeout", 32'(0), 32'(1));
    check("shift_cycles", 32'(k), 32'(n));
    check("busy_in_done", 32'(busy), 32'(1));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'(0));
    check("busy_after", 32'(busy), 32'(0));
    check("result_after", result, exp_result);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; data = '0; num = '0; shift_type = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_result", result, 32'h0);
    reset = 1'b0;

    run_op(2'b00, 32'h0000_0001, 5'd4, 1'b0);
    run_op(2'b01, 32'h8000_0000, 5'd31, 1'b0);
    run_op(2'b00, 32'h8000_0000, 5'd31, 1'b0);
    run_op(2'b10, 32'h8000_0001, 5'd1, 1'b0);
    run_op(2'b11, 32'h8000_0001, 5'd1, 1'b0);
    for (int t = 0; t < 4; t++) run_op(2'(t), 32'hDEAD_BEEF, 5'd0, 1'b0);
    run_op(2'b10, 32'h1234_5678, 5'd8, 1'b1);
    check("rotl8_hold", result, 32'h3456_7812);
    run_op(2'b00, 32'h0000_00A5, 5'd2, 1'b0);

    // Start held high: re-accepted after exactly one IDLE cycle.
    @(negedge clk);
    start = 1'b1; data = 32'hF0F0_1234; num = 5'd3; shift_type = 2'b11;
    sb_q.push_back('{res: model(2'b11, 32'hF0F0_1234, 5'd3), cyc: cyc + 4});
    sb_q.push_back('{res: model(2'b11, 32'h0BAD_CAFE, 5'd3), cyc: cyc + 9});
    @(negedge clk);
    data = 32'h0BAD_CAFE;
    wait_done(10);
    @(negedge clk);
    check("hold_idle_gap", 32'(busy), 32'(0));
    @(negedge clk);
    check("hold_reaccept", 32'(busy), 32'(1));
    start = 1'b0;
    wait_done(10);
    @(negedge clk);

    // Reset in the third SHIFT cycle aborts the operation.
    @(negedge clk);
    start = 1'b1; data = 32'h1357_9BDF; num = 5'd10; shift_type = 2'b00;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_result = '0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_result", result, 32'h0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'(0));
    end
    run_op(2'b01, 32'hCAFE_F00D, 5'd5, 1'b0);

    // Reset wins over start on the same edge.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; num = 5'd5;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    exp_result = '0;
    check("rst_prio_busy", 32'(busy), 32'(0));
    check("rst_prio_result", result, 32'h0);
    @(negedge clk);
    check("rst_prio_idle", 32'(busy), 32'(0));

    for (int i = 0; i < 20; i++)
      run_op(2'($urandom), $urandom, 5'($urandom), 1'($urandom));

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
